avm_sram16_ctrl: RTL and testbench
==================================

Name: avm_sram16_ctrl

Overview:
- Avalon-MM slave that sits directly downstream of the AHB-Lite to Avalon-MM bridge.
- Serves the bridge's single-beat 32-bit reads and writes from an external asynchronous 16-bit SRAM (CE/OE/WE/UB/LB style).
- Each 32-bit access is split into up to two halfword SRAM cycles, with programmable strobe width.
- Reads return through readdatavalid; writes are posted.

Parameters:
- ADDR_WIDTH, 17, Avalon byte address width (matches the bridge's HADDR_WIDTH).
- SRAM_AW, ADDR_WIDTH-1, SRAM halfword address width.
- WAIT_CYCLES, 2, clocks each SRAM strobe is held active; legal range 1..15.

Ports:
- avm_clk  in  1  single clock; all logic on rising edge.
- avm_rst  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_byteenable  in  4  byte lanes.
- avs_writedata  in  32  write data.
- avs_waitrequest  out  1  slave busy; master must hold the command.
- avs_readdatavalid  out  1  one-cycle pulse, readdata valid.
- avs_readdata  out  32  read data, held until the next read completes.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq_o  out  16  write data to pad.
- sram_dq_oe  out  1  pad output enable; the tristate is outside this block.
- sram_dq_i  in  16  read data from pad.
- sram_ce_n / sram_oe_n / sram_we_n / sram_ub_n / sram_lb_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (async, while avm_rst=1):
  - State=IDLE; avs_waitrequest=0; avs_readdatavalid=0; avs_readdata=0.
  - All sram_*_n=1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0.
- Acceptance: avs_waitrequest = (state != IDLE).
  - In IDLE with avs_read or avs_write high, the command is accepted on that edge: address, byteenable, writedata and direction are latched.
  - avs_read and avs_write both high: treated as a write.
- Halfword split:
  - Low half: sram_addr = {avs_address[ADDR_WIDTH-1:2], 1'b0}, lanes be[1:0].
  - High half: sram_addr = {avs_address[ADDR_WIDTH-1:2], 1'b1}, lanes be[3:2].
  - A half whose two enable bits are 0 is skipped. The low half is always processed before the high half.
  - sram_lb_n = ~be[even lane]; sram_ub_n = ~be[odd lane].
- FSM states: IDLE, SETUP, ACCESS, WHOLD, RESP.
  - SETUP (1 clk): address and lanes driven, ce_n=0, oe_n=we_n=1. For writes, sram_dq_oe=1 and data is driven.
  - ACCESS (WAIT_CYCLES clks): read has oe_n=0; write has we_n=0 with dq_oe=1. Cycle counter counts down from WAIT_CYCLES-1.
  - Read data capture: sram_dq_i is captured into the matching half of an internal buffer on the last ACCESS clock.
  - WHOLD (write only, 1 clk): we_n=1, dq_oe=1, address and data unchanged (hold time).
  - After a half completes: next enabled half -> SETUP. Otherwise a read goes to RESP and a write goes to IDLE.
  - RESP (1 clk): avs_readdatavalid=1 and avs_readdata=buffer. Lanes of a skipped half read as 0. Next state IDLE.
- Byteenable boundary cases:
  - Read with byteenable=0 is treated as 4'b1111.
  - Write with byteenable=0 performs no SRAM cycle: one busy clock (SETUP with ce_n=1), then IDLE.
- Latency, command accepted at edge T0:
  - Full-word read: readdatavalid high in cycle T0+1+2*(WAIT_CYCLES+1).
  - One-half read: readdatavalid high in cycle T0+1+(WAIT_CYCLES+1).
  - Full-word write: waitrequest low again at T0+1+2*(WAIT_CYCLES+2).
  - One-half write: waitrequest low again at T0+1+(WAIT_CYCLES+2).
- Strobe rules:
  - oe_n and we_n are never low in the same cycle.
  - dq_oe is never 1 while oe_n=0.
  - ce_n=1 in IDLE and RESP.
- Reset mid-operation: strobes are released immediately and asynchronously; the pending read is dropped with no readdatavalid; a partially written word is left as is.
- Back-to-back commands: the next command can be accepted in the first IDLE cycle; there is no dead cycle beyond the ones above.
- All outputs are registered or decoded from the state register only; no combinational path from avs_* inputs to sram_* outputs.

Test Plan:
- Reset, then write addr 0x00010 data 0xDEADBEEF be=1111, WAIT_CYCLES=2 -> SRAM halfword 0x0008=0xBEEF then 0x0009=0xDEAD; we_n low 2 clks each; waitrequest low again at T0+9.
- Read addr 0x00010 be=1111 -> readdatavalid only at T0+7, readdata=0xDEADBEEF; oe_n low 2 clks per half; dq_oe=0 throughout.
- Write be=0100 data 0x00AA0000 to 0x00010, then read full word -> one SRAM cycle to halfword 0x0009 with ub_n=1, lb_n=0; readback 0xDEAABEEF.
- Read be=0011 -> single half cycle, readdatavalid at T0+4, readdata[31:16]=0. Write be=0000 -> no ce_n pulse, busy exactly 1 clk.
- avs_read held through waitrequest with a second command queued behind a write -> second command accepted in first IDLE cycle; no duplicate accept; oe_n/we_n never overlap (assertion).
- Assert avm_rst during ACCESS of a read -> all sram_*_n=1 and dq_oe=0 immediately (same cycle); no readdatavalid; after release, a new read completes normally.

Source files
------------

// File: rtl/avm_sram16_ctrl.sv
// Avalon-MM slave that serves single-beat 32-bit reads and posted writes
// from an external asynchronous 16-bit SRAM. Each word access is split into
// up to two halfword SRAM cycles (low half first). Every SRAM strobe is held
// for WAIT_CYCLES clocks. All outputs are registered from next-state values,
// so no avs_* input reaches an sram_* pin combinationally.
module avm_sram16_ctrl #(
  parameter int ADDR_WIDTH  = 17,
  parameter int SRAM_AW     = ADDR_WIDTH - 1,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  avm_clk,
  input  logic                  avm_rst,
  input  logic [ADDR_WIDTH-1:0] avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [3:0]            avs_byteenable,
  input  logic [31:0]           avs_writedata,
  output logic                  avs_waitrequest,
  output logic                  avs_readdatavalid,
  output logic [31:0]           avs_readdata,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [15:0]           sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam int         WA       = ADDR_WIDTH - 2;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WHOLD  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t          state_r, state_nx_s;
  logic [WA-1:0]   addr_r, addr_nx_s;
  logic [3:0]      be_r, be_nx_s;
  logic [31:0]     wdata_r, wdata_nx_s;
  logic            wr_r, wr_nx_s;
  logic            half_r, half_nx_s;
  logic [3:0]      cnt_r, cnt_nx_s;
  logic [31:0]     rbuf_r, rbuf_nx_s;
  logic            more_s;
  logic            active_nx_s;
  logic            drive_nx_s;
  logic            lb_en_nx_s;
  logic            ub_en_nx_s;
  logic            addr_lsb_unused_s;

  // Byte offset bits carry no meaning for word accesses.
  assign addr_lsb_unused_s = ^avs_address[1:0];

  // Next-state and datapath-next computation for the access sequencer.
  always_comb begin
    state_nx_s = state_r;
    addr_nx_s  = addr_r;
    be_nx_s    = be_r;
    wdata_nx_s = wdata_r;
    wr_nx_s    = wr_r;
    half_nx_s  = half_r;
    cnt_nx_s   = cnt_r;
    rbuf_nx_s  = rbuf_r;
    more_s     = (half_r == 1'b0) && (be_r[3:2] != 2'b00);
    case (state_r)
      ST_IDLE: begin
        if (avs_read || avs_write) begin
          // A simultaneous read and write is served as a write.
          wr_nx_s    = avs_write;
          addr_nx_s  = avs_address[ADDR_WIDTH-1:2];
          wdata_nx_s = avs_writedata;
          if (!avs_write && (avs_byteenable == 4'b0000)) begin
            be_nx_s = 4'b1111;
          end else begin
            be_nx_s = avs_byteenable;
          end
          half_nx_s  = (be_nx_s[1:0] == 2'b00) ? 1'b1 : 1'b0;
          rbuf_nx_s  = 32'h0000_0000;
          state_nx_s = ST_SETUP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // A write with no lanes enabled burns this one busy clock and ends.
        if (be_r == 4'b0000) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ACCESS;
          cnt_nx_s   = CNT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (cnt_r != 4'd0) begin
          cnt_nx_s = cnt_r - 4'd1;
        end else if (wr_r) begin
          state_nx_s = ST_WHOLD;
        end else begin
          if (half_r) begin
            rbuf_nx_s[31:16] = sram_dq_i;
          end else begin
            rbuf_nx_s[15:0] = sram_dq_i;
          end
          if (more_s) begin
            half_nx_s  = 1'b1;
            state_nx_s = ST_SETUP;
          end else begin
            state_nx_s = ST_RESP;
          end
        end
      end
      ST_WHOLD: begin
        if (more_s) begin
          half_nx_s  = 1'b1;
          state_nx_s = ST_SETUP;
        end else if (wr_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Strobe qualifiers for the state being entered.
  always_comb begin
    active_nx_s = (state_nx_s == ST_SETUP) || (state_nx_s == ST_ACCESS) ||
                  (state_nx_s == ST_WHOLD);
    drive_nx_s  = active_nx_s && (be_nx_s != 4'b0000);
    if (half_nx_s) begin
      lb_en_nx_s = be_nx_s[2];
      ub_en_nx_s = be_nx_s[3];
    end else begin
      lb_en_nx_s = be_nx_s[0];
      ub_en_nx_s = be_nx_s[1];
    end
  end

  // State, latched command and registered Avalon/SRAM outputs.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_r           <= ST_IDLE;
      addr_r            <= '0;
      be_r              <= 4'b0000;
      wdata_r           <= 32'h0000_0000;
      wr_r              <= 1'b0;
      half_r            <= 1'b0;
      cnt_r             <= 4'd0;
      rbuf_r            <= 32'h0000_0000;
      avs_waitrequest   <= 1'b0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= 32'h0000_0000;
      sram_addr         <= '0;
      sram_dq_o         <= 16'h0000;
      sram_dq_oe        <= 1'b0;
      sram_ce_n         <= 1'b1;
      sram_oe_n         <= 1'b1;
      sram_we_n         <= 1'b1;
      sram_ub_n         <= 1'b1;
      sram_lb_n         <= 1'b1;
    end else begin
      state_r           <= state_nx_s;
      addr_r            <= addr_nx_s;
      be_r              <= be_nx_s;
      wdata_r           <= wdata_nx_s;
      wr_r              <= wr_nx_s;
      half_r            <= half_nx_s;
      cnt_r             <= cnt_nx_s;
      rbuf_r            <= rbuf_nx_s;
      avs_waitrequest   <= (state_nx_s != ST_IDLE);
      avs_readdatavalid <= (state_nx_s == ST_RESP);
      if (state_nx_s == ST_RESP) begin
        avs_readdata <= rbuf_nx_s;
      end
      if (active_nx_s) begin
        sram_addr <= SRAM_AW'({addr_nx_s, half_nx_s});
        sram_dq_o <= half_nx_s ? wdata_nx_s[31:16] : wdata_nx_s[15:0];
      end
      sram_ce_n  <= ~drive_nx_s;
      sram_oe_n  <= ~(drive_nx_s && (state_nx_s == ST_ACCESS) && !wr_nx_s);
      sram_we_n  <= ~(drive_nx_s && (state_nx_s == ST_ACCESS) && wr_nx_s);
      sram_dq_oe <= drive_nx_s && wr_nx_s;
      sram_lb_n  <= ~(drive_nx_s && lb_en_nx_s);
      sram_ub_n  <= ~(drive_nx_s && ub_en_nx_s);
    end
  end

endmodule

// File: tb/tb_avm_sram16_ctrl.sv
// Self-checking bench for avm_sram16_ctrl with a behavioural 16-bit SRAM,
// a read-data scoreboard and per-scenario tasks.
module tb_avm_sram16_ctrl;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic [16:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic        avs_readdatavalid;
  logic [31:0] avs_readdata;
  logic [15:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [31:0] sb_q[$];
  logic [15:0] mem [0:65535];

  int we_lo_cnt, oe_lo_cnt, ce_lo_cnt, dqoe_cnt, rv_cnt, acc_cnt;
  int overlap_tot  = 0;
  int conflict_tot = 0;
  logic [15:0] pulse_addr_q[$];
  logic        pulse_ub_q[$];
  logic        pulse_lb_q[$];
  logic        prev_we = 1'b1;

  avm_sram16_ctrl dut (
    .avm_clk           (avm_clk),
    .avm_rst           (avm_rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_byteenable    (avs_byteenable),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_readdata      (avs_readdata),
    .sram_addr         (sram_addr),
    .sram_dq_o         (sram_dq_o),
    .sram_dq_oe        (sram_dq_oe),
    .sram_dq_i         (sram_dq_i),
    .sram_ce_n         (sram_ce_n),
    .sram_oe_n         (sram_oe_n),
    .sram_we_n         (sram_we_n),
    .sram_ub_n         (sram_ub_n),
    .sram_lb_n         (sram_lb_n)
  );

  always #5 avm_clk = ~avm_clk;

  // Free-running cycle count, used to measure accept-to-accept spacing.
  always @(posedge avm_clk) cyc <= cyc + 1;

  // SRAM read path.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  // SRAM write path with byte lanes.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    forever begin
      @(posedge avm_clk);
      if (!avm_rst && !sram_ce_n && !sram_we_n && sram_dq_oe) begin
        if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq_o[7:0];
        if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq_o[15:8];
      end
    end
  end

  // Count accepted commands.
  initial begin
    forever begin
      @(posedge avm_clk);
      if (!avm_rst && (avs_read || avs_write) && !avs_waitrequest) acc_cnt++;
    end
  end

  // Strobe monitor and read-data scoreboard.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge avm_clk);
      if (!avm_rst) begin
        if (!sram_we_n) we_lo_cnt++;
        if (!sram_oe_n) oe_lo_cnt++;
        if (!sram_ce_n) ce_lo_cnt++;
        if (sram_dq_oe) dqoe_cnt++;
        if (!sram_we_n && !sram_oe_n) overlap_tot++;
        if (sram_dq_oe && !sram_oe_n) conflict_tot++;
        if (!sram_we_n && prev_we) begin
          pulse_addr_q.push_back(sram_addr);
          pulse_ub_q.push_back(sram_ub_n);
          pulse_lb_q.push_back(sram_lb_n);
        end
        if (avs_readdatavalid) begin
          rv_cnt++;
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_rvalid: readdata=%h with no read pending", avs_readdata);
          end else begin
            exp = sb_q.pop_front();
            if (avs_readdata !== exp) begin
              miscompares++;
              $display("FAIL readdata: got %h expected %h", avs_readdata, exp);
            end
          end
        end
      end
      prev_we = sram_we_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    #1;
    we_lo_cnt = 0; oe_lo_cnt = 0; ce_lo_cnt = 0; dqoe_cnt = 0;
    rv_cnt = 0; acc_cnt = 0;
    pulse_addr_q.delete(); pulse_ub_q.delete(); pulse_lb_q.delete();
  endtask

  task automatic issue(input bit wr, input logic [16:0] a, input logic [3:0] be,
                       input logic [31:0] d, output int t0);
    bit w;
    bit done = 1'b0;
    t0 = -1;
    @(negedge avm_clk);
    avs_write = wr; avs_read = !wr;
    avs_address = a; avs_byteenable = be; avs_writedata = d;
    for (int i = 0; i < 60 && !done; i++) begin
      w = avs_waitrequest;
      @(posedge avm_clk);
      if (!w) begin
        done = 1'b1;
        #1 t0 = cyc;
      end else begin
        @(negedge avm_clk);
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL accept: command at %h not accepted within 60 clocks", a);
    end
  endtask

  task automatic wait_rvalid(input int exp_k, input string name);
    int  k = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge avm_clk);
      avs_read = 1'b0; avs_write = 1'b0;
      k = i;
      if (avs_readdatavalid) seen = 1'b1;
    end
    vectors++;
    if (!seen || k != exp_k) begin
      miscompares++;
      $display("FAIL %s_latency: rvalid seen=%0d at cycle %0d, expected cycle %0d", name, seen, k, exp_k);
    end
    @(negedge avm_clk);
    vectors++;
    if (avs_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_pulse: rvalid=%b one cycle later, expected 0", name, avs_readdatavalid);
    end
  endtask

  task automatic wait_idle(input int exp_k, input string name);
    int k = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge avm_clk);
      avs_read = 1'b0; avs_write = 1'b0;
      k = i;
      if (!avs_waitrequest) seen = 1'b1;
    end
    vectors++;
    if (!seen || k != exp_k) begin
      miscompares++;
      $display("FAIL %s_busy: waitrequest low seen=%0d at cycle %0d, expected cycle %0d", name, seen, k, exp_k);
    end
  endtask

  task automatic test_reset();
    logic [71:0] got;
    logic [71:0] exp;
    exp = {1'b0, 1'b0, 32'h0, 5'b11111, 1'b0, 16'h0, 16'h0};
    avm_rst = 1'b1;
    avs_read = 1'b0; avs_write = 1'b0;
    avs_address = 17'h0; avs_byteenable = 4'h0; avs_writedata = 32'h0;
    repeat (3) @(negedge avm_clk);
    got = {avs_waitrequest, avs_readdatavalid, avs_readdata,
           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
           sram_dq_oe, sram_addr, sram_dq_o};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_in: got %h expected %h", got, exp);
    end
    avm_rst = 1'b0;
    repeat (2) @(negedge avm_clk);
    got = {avs_waitrequest, avs_readdatavalid, avs_readdata,
           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
           sram_dq_oe, sram_addr, sram_dq_o};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_write_full();
    int t0;
    logic [47:0] got;
    clear_mon();
    issue(1'b1, 17'h00010, 4'hF, 32'hDEADBEEF, t0);
    wait_idle(9, "wr_full");
    got = {16'(pulse_addr_q.size()),
           (pulse_addr_q.size() > 0) ? pulse_addr_q[0] : 16'hFFFF,
           (pulse_addr_q.size() > 1) ? pulse_addr_q[1] : 16'hFFFF};
    vectors++;
    if (got !== {16'd2, 16'h0008, 16'h0009}) begin
      miscompares++;
      $display("FAIL wr_full_order: got %h expected 000200080009", got);
    end
    vectors++;
    if (we_lo_cnt != 4 || dqoe_cnt != 8) begin
      miscompares++;
      $display("FAIL wr_full_strobes: we_low=%0d dq_oe=%0d expected 4 and 8", we_lo_cnt, dqoe_cnt);
    end
    vectors++;
    if ({mem[8], mem[9]} !== {16'hBEEF, 16'hDEAD}) begin
      miscompares++;
      $display("FAIL wr_full_mem: got %h %h expected BEEF DEAD", mem[8], mem[9]);
    end
  endtask

  task automatic test_read_full();
    int t0;
    clear_mon();
    sb_q.push_back(32'hDEADBEEF);
    issue(1'b0, 17'h00010, 4'hF, 32'h0, t0);
    wait_rvalid(7, "rd_full");
    vectors++;
    if (oe_lo_cnt != 4 || dqoe_cnt != 0 || rv_cnt != 1) begin
      miscompares++;
      $display("FAIL rd_full_strobes: oe_low=%0d dq_oe=%0d rvalid=%0d expected 4 0 1", oe_lo_cnt, dqoe_cnt, rv_cnt);
    end
  endtask

  task automatic test_write_partial();
    int t0;
    logic [17:0] got;
    clear_mon();
    issue(1'b1, 17'h00010, 4'b0100, 32'h00AA0000, t0);
    wait_idle(5, "wr_part");
    got = {16'(pulse_addr_q.size()) == 16'd1 ? pulse_addr_q[0] : 16'hFFFF,
           (pulse_ub_q.size() > 0) ? pulse_ub_q[0] : 1'bx,
           (pulse_lb_q.size() > 0) ? pulse_lb_q[0] : 1'bx};
    vectors++;
    if (got !== {16'h0009, 1'b1, 1'b0} || we_lo_cnt != 2) begin
      miscompares++;
      $display("FAIL wr_part_pulse: addr/ub/lb=%h we_low=%0d expected 0009/1/0 and 2", got, we_lo_cnt);
    end
    clear_mon();
    sb_q.push_back(32'hDEAABEEF);
    issue(1'b0, 17'h00010, 4'hF, 32'h0, t0);
    wait_rvalid(7, "rd_after_part");
  endtask

  task automatic test_read_half();
    int t0;
    clear_mon();
    sb_q.push_back(32'h0000BEEF);
    issue(1'b0, 17'h00010, 4'b0011, 32'h0, t0);
    wait_rvalid(4, "rd_half");
    vectors++;
    if (oe_lo_cnt != 2) begin
      miscompares++;
      $display("FAIL rd_half_strobes: oe_low=%0d expected 2", oe_lo_cnt);
    end
    clear_mon();
    sb_q.push_back(32'hDEAABEEF);
    issue(1'b0, 17'h00012, 4'b0000, 32'h0, t0);
    wait_rvalid(7, "rd_be0");
  endtask

  task automatic test_write_be0();
    int t0;
    clear_mon();
    issue(1'b1, 17'h00010, 4'b0000, 32'hFFFFFFFF, t0);
    wait_idle(2, "wr_be0");
    vectors++;
    if (ce_lo_cnt != 0 || {mem[8], mem[9]} !== {16'hBEEF, 16'hDEAA}) begin
      miscompares++;
      $display("FAIL wr_be0_nocycle: ce_low=%0d mem=%h %h expected 0 BEEF DEAA", ce_lo_cnt, mem[8], mem[9]);
    end
  endtask

  task automatic test_back_to_back();
    int tw, tr;
    clear_mon();
    issue(1'b1, 17'h00040, 4'hF, 32'h12345678, tw);
    sb_q.push_back(32'h12345678);
    issue(1'b0, 17'h00040, 4'hF, 32'h0, tr);
    vectors++;
    if (tr - tw != 9) begin
      miscompares++;
      $display("FAIL b2b_accept: read accepted %0d clocks after write, expected 9", tr - tw);
    end
    wait_rvalid(7, "b2b_rd");
    vectors++;
    if (acc_cnt != 2) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d accepts expected 2", acc_cnt);
    end
    vectors++;
    if (overlap_tot != 0 || conflict_tot != 0) begin
      miscompares++;
      $display("FAIL strobe_rules: oe/we overlap=%0d dq_oe with oe=%0d expected 0 0", overlap_tot, conflict_tot);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int rvb;
    bit hit = 1'b0;
    logic [7:0] got;
    clear_mon();
    sb_q.push_back(32'hDEAABEEF);
    issue(1'b0, 17'h00010, 4'hF, 32'h0, t0);
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge avm_clk);
      avs_read = 1'b0;
      if (!sram_oe_n) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rst_mid_access: oe_n never went low, got 0 expected 1");
    end
    #2 avm_rst = 1'b1;
    #1 got = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
              sram_dq_oe, avs_readdatavalid, avs_waitrequest};
    vectors++;
    if (got !== 8'b11111_0_0_0) begin
      miscompares++;
      $display("FAIL rst_mid_strobes: got %b expected 11111000", got);
    end
    sb_q.delete();
    rvb = rv_cnt;
    repeat (2) @(negedge avm_clk);
    avm_rst = 1'b0;
    repeat (8) @(negedge avm_clk);
    vectors++;
    if (rv_cnt != rvb) begin
      miscompares++;
      $display("FAIL rst_mid_drop: rvalid count %0d expected %0d", rv_cnt, rvb);
    end
    sb_q.push_back(32'hDEAABEEF);
    issue(1'b0, 17'h00010, 4'hF, 32'h0, t0);
    wait_rvalid(7, "rd_after_rst");
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_read_full();
    test_write_partial();
    test_read_half();
    test_write_be0();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge avm_clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
